// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO for any depth >= 2, with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable first-word-fall-through read port.
module sync_fifo_flagged #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 1,
  parameter bit FWFT       = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w_inc,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         r_inc,
  input  logic                         clr_err,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  rd_acc;
  logic                  wr_acc;

  // Flags come only from the registered count, so no request input reaches a flag combinationally.
  assign count        = count_q;
  assign full         = (count_q == FULL_LVL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);

  // A full FIFO still takes a write when the same cycle frees a slot.
  assign rd_acc = r_inc & ~empty;
  assign wr_acc = w_inc & (~full | rd_acc);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr] <= wr_data;
  end

  // Sticky error flags: a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_inc && !wr_acc) overflow <= 1'b1;
      else if (clr_err)     overflow <= 1'b0;
      if (r_inc && empty)   underflow <= 1'b1;
      else if (clr_err)     underflow <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign rd_data  = mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rd_ptr];
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Bench for sync_fifo_flagged: three configurations (depth 8 registered, depth 5 registered,
// depth 4 FWFT) driven together and compared every cycle against a queue-based reference model.
module tb_sync_fifo_flagged;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus, one slot per configuration.
  logic       w_s   [N];
  logic       r_s   [N];
  logic       clr_s [N];
  logic       rst_s [N];
  logic [7:0] d_s   [N];

  wire [7:0] rd_data_o [N];
  wire [N-1:0] rd_valid_o, full_o, empty_o, af_o, ae_o, ovf_o, unf_o;
  wire [3:0] cnt8;
  wire [2:0] cnt5;
  wire [2:0] cntf;

  sync_fifo_flagged #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1'b0)) u_d8 (
    .clk(clk), .rst(rst_s[0]), .w_inc(w_s[0]), .wr_data(d_s[0]), .r_inc(r_s[0]),
    .clr_err(clr_s[0]), .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]),
    .full(full_o[0]), .empty(empty_o[0]), .almost_full(af_o[0]), .almost_empty(ae_o[0]),
    .count(cnt8), .overflow(ovf_o[0]), .underflow(unf_o[0]));

  sync_fifo_flagged #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1'b0)) u_d5 (
    .clk(clk), .rst(rst_s[1]), .w_inc(w_s[1]), .wr_data(d_s[1]), .r_inc(r_s[1]),
    .clr_err(clr_s[1]), .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]),
    .full(full_o[1]), .empty(empty_o[1]), .almost_full(af_o[1]), .almost_empty(ae_o[1]),
    .count(cnt5), .overflow(ovf_o[1]), .underflow(unf_o[1]));

  sync_fifo_flagged #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1'b1)) u_fw (
    .clk(clk), .rst(rst_s[2]), .w_inc(w_s[2]), .wr_data(d_s[2]), .r_inc(r_s[2]),
    .clr_err(clr_s[2]), .rd_data(rd_data_o[2]), .rd_valid(rd_valid_o[2]),
    .full(full_o[2]), .empty(empty_o[2]), .almost_full(af_o[2]), .almost_empty(ae_o[2]),
    .count(cntf), .overflow(ovf_o[2]), .underflow(unf_o[2]));

  // Configuration of each instance as seen by the model.
  int depth_c [N] = '{8, 5, 4};
  int af_c    [N] = '{6, 3, 2};
  int ae_c    [N] = '{1, 1, 1};
  bit fwft_c  [N] = '{1'b0, 1'b0, 1'b1};

  // Reference model: contents as a plain queue plus the externally visible registers.
  logic [7:0] mq [N][$];
  logic [7:0] m_rd  [N];
  bit         m_vld [N];
  bit         m_ovf [N];
  bit         m_unf [N];
  bit         m_rst_seen [N];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_count(input int i);
    case (i)
      0:       return {28'd0, cnt8};
      1:       return {29'd0, cnt5};
      default: return {29'd0, cntf};
    endcase
  endfunction

  task automatic model_step(input int i);
    int  n;
    bit  rd_ok, wr_ok;
    logic [7:0] popped;
    popped = 8'h00;
    if (rst_s[i]) begin
      mq[i].delete();
      m_rd[i]  = 8'h00;
      m_vld[i] = 1'b0;
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
      m_rst_seen[i] = 1'b1;
      return;
    end
    n     = mq[i].size();
    rd_ok = r_s[i] && (n > 0);
    wr_ok = w_s[i] && ((n < depth_c[i]) || rd_ok);
    if (w_s[i] && !wr_ok)   m_ovf[i] = 1'b1;
    else if (clr_s[i])      m_ovf[i] = 1'b0;
    if (r_s[i] && (n == 0)) m_unf[i] = 1'b1;
    else if (clr_s[i])      m_unf[i] = 1'b0;
    if (rd_ok) popped = mq[i].pop_front();
    if (wr_ok) mq[i].push_back(d_s[i]);
    if (!fwft_c[i]) begin
      m_vld[i] = rd_ok;
      if (rd_ok) m_rd[i] = popped;
    end
  endtask

  task automatic check_inst(input int i);
    int n;
    n = mq[i].size();
    check("count",        i, obs_count(i),   32'(n));
    check("full",         i, 32'(full_o[i]),  32'(n == depth_c[i]));
    check("empty",        i, 32'(empty_o[i]), 32'(n == 0));
    check("almost_full",  i, 32'(af_o[i]),    32'(n >= af_c[i]));
    check("almost_empty", i, 32'(ae_o[i]),    32'(n <= ae_c[i]));
    check("overflow",     i, 32'(ovf_o[i]),   32'(m_ovf[i]));
    check("underflow",    i, 32'(unf_o[i]),   32'(m_unf[i]));
    if (fwft_c[i]) begin
      check("rd_valid", i, 32'(rd_valid_o[i]), 32'(n > 0));
      if (n > 0) check("rd_data", i, 32'(rd_data_o[i]), 32'(mq[i][0]));
    end else begin
      check("rd_valid", i, 32'(rd_valid_o[i]), 32'(m_vld[i]));
      check("rd_data",  i, 32'(rd_data_o[i]),  32'(m_rd[i]));
    end
  endtask

  // One clock: stimulus already on the inputs, model follows the edge, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < N; i++) model_step(i);
    #1;
    for (int i = 0; i < N; i++) if (m_rst_seen[i]) check_inst(i);
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      w_s[i] = 1'b0; r_s[i] = 1'b0; clr_s[i] = 1'b0; rst_s[i] = 1'b0; d_s[i] = 8'h00;
    end
  endtask

  task automatic op(input int i, input bit w, input logic [7:0] d, input bit r,
                    input bit clr = 1'b0, input bit rs = 1'b0);
    idle_all();
    w_s[i] = w; d_s[i] = d; r_s[i] = r; clr_s[i] = clr; rst_s[i] = rs;
    tick();
  endtask

  initial begin
    logic [7:0] order5 [7];
    idle_all();
    for (int i = 0; i < N; i++) begin
      rst_s[i] = 1'b1;
      m_rst_seen[i] = 1'b0;
    end
    tick();
    idle_all();

    // Basic order on depth 8: four writes, four reads with one-cycle rd_valid pulses.
    op(0, 1, 8'd10, 0);
    op(0, 1, 8'd20, 0);
    op(0, 1, 8'd80, 0);
    op(0, 1, 8'd30, 0);
    for (int k = 0; k < 4; k++) op(0, 0, 8'h00, 1);
    op(0, 0, 8'h00, 0);

    // Fill to full, then a dropped ninth write.
    for (int k = 0; k < 8; k++) op(0, 1, 8'(40 + 10 * k), 0);
    op(0, 1, 8'd120, 0);
    // Full with both requests: count stays at depth.
    op(0, 1, 8'd130, 1);
    for (int k = 0; k < 8; k++) op(0, 0, 8'h00, 1);
    // Empty with both requests: write lands, read rejected.
    op(0, 1, 8'd140, 1);
    op(0, 0, 8'h00, 0);

    // Errors then reset: three words stored, clear flags, reset, read empty.
    op(0, 1, 8'd150, 0);
    op(0, 1, 8'd160, 0);
    op(0, 0, 8'h00, 0, 1'b1);
    op(0, 0, 8'h00, 0, 1'b0, 1'b1);
    op(0, 0, 8'h00, 1);

    // Wrap-around on depth 5 with occupancy kept at or below three.
    order5 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    op(1, 1, order5[0], 0);
    op(1, 1, order5[1], 0);
    op(1, 1, order5[2], 0);
    for (int k = 3; k < 7; k++) begin
      op(1, 0, 8'h00, 1);
      op(1, 1, order5[k], 0);
    end
    for (int k = 0; k < 3; k++) op(1, 0, 8'h00, 1);
    op(1, 0, 8'h00, 0);

    // FWFT: the word shows without a read request, and a pop empties it.
    op(2, 1, 8'hA5, 0);
    op(2, 0, 8'h00, 0);
    op(2, 0, 8'h00, 1);

    // Randomised phases: write-heavy, read-heavy, balanced.
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 150; c++) begin
        for (int i = 0; i < N; i++) begin
          int wp, rp;
          wp = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
          rp = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
          w_s[i]   = ($urandom_range(99) < wp);
          r_s[i]   = ($urandom_range(99) < rp);
          clr_s[i] = ($urandom_range(99) < 5);
          rst_s[i] = ($urandom_range(199) == 0);
          d_s[i]   = 8'($urandom);
        end
        tick();
      end
    end

    idle_all();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flagged.md
Name: sync_fifo_flagged

Overview:
Single-clock, parametrised FIFO. It is the same-domain successor of the dual-clock FIFO and is used where producer and consumer share one clock. Over the basic FULL/EMPTY FIFO it adds:
- any depth, not only powers of two
- occupancy count
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- selectable first-word-fall-through (FWFT) read mode

It sits between register-file/UART-style blocks inside one clock domain.

Parameters:
- DATA_WIDTH, 8: width of each stored word.
- DEPTH, 8: number of entries; any value ≥ 2.
- AF_LEVEL, DEPTH-2: ALMOST_FULL asserts when COUNT ≥ AF_LEVEL.
- AE_LEVEL, 1: ALMOST_EMPTY asserts when COUNT ≤ AE_LEVEL.
- FWFT, 0: 0 = registered read with 1-cycle latency; 1 = first-word-fall-through.

Ports:
- CLK  in  1  Clock; everything samples on the rising edge.
- RST  in  1  Reset, synchronous, active-high.
- W_INC  in  1  Write request.
- WR_DATA  in  DATA_WIDTH  Write data.
- R_INC  in  1  Read/pop request.
- RD_DATA  out  DATA_WIDTH  Read data.
- RD_VALID  out  1  RD_DATA is valid.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- ALMOST_FULL  out  1  COUNT ≥ AF_LEVEL.
- ALMOST_EMPTY  out  1  COUNT ≤ AE_LEVEL.
- COUNT  out  $clog2(DEPTH+1)  Current occupancy.
- OVERFLOW  out  1  Sticky: a write was dropped.
- UNDERFLOW  out  1  Sticky: a read was attempted while empty.
- CLR_ERR  in  1  Clears OVERFLOW and UNDERFLOW.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous, active-high.
- Reset values, all in the cycle after RST is sampled high:
  - write/read pointers = 0, COUNT = 0
  - EMPTY = 1, FULL = 0, ALMOST_EMPTY = 1, ALMOST_FULL = 0
  - RD_DATA = 0, RD_VALID = 0, OVERFLOW = 0, UNDERFLOW = 0
  - Memory array is not reset.
- Reset asserted mid-operation discards all contents and has priority over every request in that cycle.
- Read accept: rd_acc = R_INC & ~EMPTY.
- Write accept: wr_acc = W_INC & (~FULL | rd_acc).
  - A write to a full FIFO succeeds only if a read is accepted in the same cycle.
- Simultaneous requests:
  - Full, both requests: both are accepted and COUNT is unchanged.
  - Empty, both requests: only the write is accepted; the read is rejected and sets UNDERFLOW. There is no pass-through of write data to RD_DATA.
- Pointers: increment on accept and wrap from DEPTH-1 to 0 by explicit compare, so non-power-of-2 depths work.
- COUNT is a register updated each cycle:
  - +1 on wr_acc & ~rd_acc
  - -1 on rd_acc & ~wr_acc
  - unchanged otherwise
- FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY are decoded from registered COUNT only. There is no combinational path from W_INC/R_INC to any flag.
- FWFT = 0:
  - On rd_acc, RD_DATA is loaded with mem[rd_ptr] at the next edge; RD_VALID pulses high for exactly that one cycle.
  - RD_DATA holds its last value otherwise.
  - Read latency is 1 cycle.
- FWFT = 1:
  - RD_DATA = mem[rd_ptr] combinationally; RD_VALID = ~EMPTY.
  - R_INC with RD_VALID high pops the word shown.
  - Reset value 0 is not guaranteed on RD_DATA in this mode; only RD_VALID = 0 is.
- Write-to-read visibility: a word written at edge N is readable from edge N+1.
  - FWFT = 1: RD_VALID is high in the cycle after the first write into an empty FIFO.
- OVERFLOW is set at the edge where W_INC & ~wr_acc.
- UNDERFLOW is set at the edge where R_INC & EMPTY.
- OVERFLOW and UNDERFLOW stay set until CLR_ERR or RST. If set and CLR_ERR coincide, set wins.
- Rejected requests leave pointers, COUNT and memory unchanged.

Test Plan:
- Basic order: DEPTH=8, FWFT=0. After reset, write 10, 20, 80, 30, then R_INC for 4 cycles -> RD_DATA = 10, 20, 80, 30, each with a one-cycle RD_VALID pulse; COUNT steps 4→0; EMPTY=1 at the end; no error flags.
- Fill and overflow: write 40..110 (8 words) -> FULL=1, COUNT=8, ALMOST_FULL=1 from COUNT=6. A 9th write of 120 -> OVERFLOW=1, COUNT stays 8; subsequent reads return 40..110 and never 120.
- Simultaneous read/write while full -> write accepted, COUNT stays 8, FULL stays 1. When empty, same stimulus -> COUNT=1, UNDERFLOW=1, RD_VALID stays 0.
- Wrap-around: DEPTH=5. Push 7 and pop 7 words, interleaved with occupancy ≤ 3 -> data order preserved across the pointer wrap 4→0; ALMOST_EMPTY toggles exactly at COUNT ≤ 1.
- FWFT=1: write 0xA5 into an empty FIFO -> next cycle RD_VALID=1, RD_DATA=0xA5 with no R_INC; after R_INC, RD_VALID=0.
- Errors and reset: with 3 words stored and OVERFLOW=1, CLR_ERR=1 for one cycle -> OVERFLOW=0, data untouched. Then RST=1 for one cycle -> COUNT=0, EMPTY=1, RD_VALID=0; a following read sets UNDERFLOW.
